// File: rtl/lock_entry_controller.sv
// Keypad password-entry sequencer: collects digits, checks the password, holds unlock, enforces lockout.
// Optional run-time password change is enabled with `define SMARTLOCK_PWCHANGE_EN.
module lock_entry_controller #(
    parameter int                   DIGITS      = 4,
    parameter logic [4*DIGITS-1:0]  PASSWORD    = 16'h1234,
    parameter int                   MAX_FAIL    = 3,
    parameter int                   UNLOCK_CYC  = 50_000_000,
    parameter int                   LOCKOUT_CYC = 500_000_000,
    parameter int                   TIMEOUT_CYC = 250_000_000,
    parameter logic [3:0]           CLEAR_KEY   = 4'hC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       unlock,
    output logic       entry_active,
    output logic [3:0] count,
    output logic [2:0] fail_cnt,
    output logic       lockout,
    output logic       fail_pulse,
    output logic [2:0] state
);

    localparam int PW_W = 4 * DIGITS;

    localparam int MAX_UL  = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int MAX_CYC = (MAX_UL > TIMEOUT_CYC) ? MAX_UL : TIMEOUT_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] UNLOCK_LAST  = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       DIGITS_C     = 4'(DIGITS);
    localparam logic [2:0]       MAX_FAIL_C   = 3'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_FAIL     = 3'd4,
        S_LOCKOUT  = 3'd5,
        S_NEWPW    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [PW_W-1:0]    buffer_q, buffer_d;
    logic [3:0]         count_d;
    logic [2:0]         fail_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               clear_entry;
    logic               is_digit;
    logic               is_clear;
    logic [PW_W-1:0]    pw_q;

`ifdef SMARTLOCK_PWCHANGE_EN
    logic [PW_W-1:0]    pw_d;
    logic               is_pwkey;

    assign is_pwkey = key_valid && (key_code == 4'hA);
`else
    assign pw_q = PASSWORD;
`endif

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_clear = key_valid && (key_code == CLEAR_KEY);
    assign state    = state_q;

    always_comb begin
        state_d     = state_q;
        buffer_d    = buffer_q;
        count_d     = count;
        fail_d      = fail_cnt;
        timer_d     = timer_q + 1'b1;
        clear_entry = 1'b0;
`ifdef SMARTLOCK_PWCHANGE_EN
        pw_d        = pw_q;
`endif

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (is_digit) begin
                    buffer_d = PW_W'(key_code);
                    count_d  = 4'd1;
                    state_d  = S_ENTRY;
                end
            end

            // NEWPW reuses the ENTRY digit/clear/timeout rules; only the full-buffer action differs.
            S_ENTRY, S_NEWPW: begin
                if (count == DIGITS_C) begin
                    if (state_q == S_NEWPW) begin
`ifdef SMARTLOCK_PWCHANGE_EN
                        pw_d = buffer_q;
`endif
                        clear_entry = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else if (is_digit) begin
                    buffer_d = (buffer_q << 4) | PW_W'(key_code);
                    count_d  = count + 4'd1;
                    timer_d  = '0;
                end else if (is_clear) begin
                    clear_entry = 1'b1;
                    state_d     = S_IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    clear_entry = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            S_CHECK: begin
                if (buffer_q == pw_q) begin
                    fail_d  = 3'd0;
                    state_d = S_UNLOCKED;
                end else begin
                    clear_entry = 1'b1;
                    fail_d      = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;
                    state_d     = S_FAIL;
                end
            end

            S_UNLOCKED: begin
`ifdef SMARTLOCK_PWCHANGE_EN
                if (is_pwkey) begin
                    clear_entry = 1'b1;
                    state_d     = S_NEWPW;
                end else
`endif
                if (timer_q == UNLOCK_LAST) begin
                    clear_entry = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            S_FAIL: begin
                state_d = (fail_cnt == MAX_FAIL_C) ? S_LOCKOUT : S_IDLE;
            end

            S_LOCKOUT: begin
                if (timer_q == LOCKOUT_LAST) begin
                    fail_d  = 3'd0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                clear_entry = 1'b1;
                state_d     = S_IDLE;
            end
        endcase

        if (clear_entry) begin
            buffer_d = '0;
            count_d  = 4'd0;
        end

        // Every state change restarts the shared timer from zero.
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            buffer_q     <= '0;
            count        <= 4'd0;
            fail_cnt     <= 3'd0;
            timer_q      <= '0;
            unlock       <= 1'b0;
            entry_active <= 1'b0;
            lockout      <= 1'b0;
            fail_pulse   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buffer_q     <= buffer_d;
            count        <= count_d;
            fail_cnt     <= fail_d;
            timer_q      <= timer_d;
            unlock       <= (state_d == S_UNLOCKED);
            entry_active <= (state_d == S_ENTRY) || (state_d == S_NEWPW);
            lockout      <= (state_d == S_LOCKOUT);
            fail_pulse   <= (state_d == S_FAIL);
        end
    end

`ifdef SMARTLOCK_PWCHANGE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pw_q <= PASSWORD;
        end else begin
            pw_q <= pw_d;
        end
    end
`endif

endmodule

// File: tb/tb_lock_entry_controller.sv
// Bench for lock_entry_controller: queue/countdown model checked every cycle plus directed literal checks.
// Define SMARTLOCK_PWCHANGE_EN for both files to exercise the password-change scenarios.
module tb_lock_entry_controller;

    localparam int          DIGITS      = 4;
    localparam logic [15:0] PASSWORD    = 16'h1234;
    localparam int          MAX_FAIL    = 3;
    localparam int          UNLOCK_CYC  = 8;
    localparam int          LOCKOUT_CYC = 20;
    localparam int          TIMEOUT_CYC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       unlock;
    logic       entry_active;
    logic [3:0] count;
    logic [2:0] fail_cnt;
    logic       lockout;
    logic       fail_pulse;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;
    int lock_cycles = 0;
    int unlock_cycles = 0;

    lock_entry_controller #(
        .DIGITS(DIGITS), .PASSWORD(PASSWORD), .MAX_FAIL(MAX_FAIL),
        .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .CLEAR_KEY(4'hC)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .unlock(unlock), .entry_active(entry_active), .count(count),
        .fail_cnt(fail_cnt), .lockout(lockout), .fail_pulse(fail_pulse),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: entered digits as a queue, timed phases as countdowns.
    int m_phase = 0;
    int m_fail = 0;
    int m_left = 0;
    int m_idle = 0;
    int m_pw = PASSWORD;
    int m_digits[$];
    bit m_digit;
    bit m_clear;

    function automatic int digits_value(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_fail = 0; m_left = 0; m_idle = 0;
            m_pw = PASSWORD; m_digits = {};
        end else begin
            m_digit = key_valid && (key_code <= 4'd9);
            m_clear = key_valid && (key_code == 4'hC);
            case (m_phase)
                0: if (m_digit) begin
                    m_digits = {int'(key_code)};
                    m_idle = TIMEOUT_CYC;
                    m_phase = 1;
                end
                1, 6: begin
                    if (m_digits.size() == DIGITS) begin
                        if (m_phase == 6) begin
                            m_pw = digits_value(m_digits);
                            m_digits = {};
                            m_phase = 0;
                        end else begin
                            m_phase = 2;
                        end
                    end else if (m_digit) begin
                        m_digits.push_back(int'(key_code));
                        m_idle = TIMEOUT_CYC;
                    end else if (m_clear) begin
                        m_digits = {};
                        m_phase = 0;
                    end else begin
                        m_idle--;
                        if (m_idle == 0) begin
                            m_digits = {};
                            m_phase = 0;
                        end
                    end
                end
                2: if (digits_value(m_digits) == m_pw) begin
                    m_fail = 0;
                    m_left = UNLOCK_CYC;
                    m_phase = 3;
                end else begin
                    m_digits = {};
                    m_fail = (m_fail < 7) ? m_fail + 1 : 7;
                    m_phase = 4;
                end
                3: begin
`ifdef SMARTLOCK_PWCHANGE_EN
                    if (key_valid && key_code == 4'hA) begin
                        m_digits = {};
                        m_idle = TIMEOUT_CYC;
                        m_phase = 6;
                    end else
`endif
                    begin
                        m_left--;
                        if (m_left == 0) begin
                            m_digits = {};
                            m_phase = 0;
                        end
                    end
                end
                4: if (m_fail == MAX_FAIL) begin
                    m_left = LOCKOUT_CYC;
                    m_phase = 5;
                end else begin
                    m_phase = 0;
                end
                5: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_fail = 0;
                        m_phase = 0;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_output("state", state, m_phase);
            check_output("unlock", unlock, m_phase == 3);
            check_output("entry_active", entry_active, (m_phase == 1) || (m_phase == 6));
            check_output("count", count, m_digits.size());
            check_output("fail_cnt", fail_cnt, m_fail);
            check_output("lockout", lockout, m_phase == 5);
            check_output("fail_pulse", fail_pulse, m_phase == 4);
        end
        if (lockout === 1'b1) lock_cycles++;
        if (unlock === 1'b1) unlock_cycles++;
    end

    task automatic press(input logic [3:0] k, input int gap);
        @(negedge clk);
        key_valid = 1'b1;
        key_code = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code = 4'd0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic code_entry(input logic [15:0] code, input int gap);
        for (int i = 3; i >= 0; i--) press(code[i*4 +: 4], gap);
    endtask

    // Called one cycle after the last digit was sampled.
    task automatic expect_unlock();
        int n = 0;
        check_output("count_full", count, 4);
        @(negedge clk);
        check_output("check_state", state, 2);
        @(negedge clk);
        check_output("unlock_rise", unlock, 1);
        check_output("unlock_fail_cnt", fail_cnt, 0);
        while (unlock === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output("unlock_len", n, 8);
        check_output("post_unlock_state", state, 0);
        check_output("post_unlock_count", count, 0);
    endtask

    task automatic expect_fail(input int new_fail);
        check_output("fail_count_full", count, 4);
        @(negedge clk);
        check_output("fail_check_state", state, 2);
        @(negedge clk);
        check_output("fail_pulse_hi", fail_pulse, 1);
        check_output("fail_cnt_new", fail_cnt, new_fail);
        check_output("fail_no_unlock", unlock, 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        #2 rst = 1'b0;
        checking = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset_state", state, 0);
        check_output("reset_unlock", unlock, 0);
        rst = 1'b1;

        $display("[TB] correct code with gaps");
        press(4'd1, 3); press(4'd2, 3); press(4'd3, 3); press(4'd4, 0);
        expect_unlock();

        $display("[TB] three failures then lockout");
        code_entry(16'h1235, 0); expect_fail(1);
        @(negedge clk);
        check_output("fail_pulse_low", fail_pulse, 0);
        check_output("fail1_idle", state, 0);
        code_entry(16'h1235, 0); expect_fail(2);
        @(negedge clk);
        code_entry(16'h1235, 0); expect_fail(3);
        lock_cycles = 0;
        unlock_cycles = 0;
        @(negedge clk);
        check_output("lockout_state", state, 5);
        check_output("lockout_hi", lockout, 1);
        code_entry(16'h1234, 0);
        n = 0;
        while (lockout === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("lockout_len", lock_cycles, 20);
        check_output("lockout_no_unlock", unlock_cycles, 0);
        check_output("lockout_fail_clr", fail_cnt, 0);
        check_output("lockout_count", count, 0);

        $display("[TB] entry timeout");
        code_entry(16'h1235, 0); expect_fail(1);
        @(negedge clk);
        press(4'd1, 0); press(4'd2, 0);
        check_output("timeout_count2", count, 2);
        repeat (15) @(negedge clk);
        check_output("pre_timeout_state", state, 1);
        @(negedge clk);
        check_output("timeout_state", state, 0);
        check_output("timeout_count", count, 0);
        check_output("timeout_fail_kept", fail_cnt, 1);
        code_entry(16'h1234, 0); expect_unlock();

        $display("[TB] clear key and ignored codes");
        press(4'd1, 0); press(4'd2, 0);
        check_output("pre_clear_count", count, 2);
        press(4'hC, 0);
        check_output("clear_count", count, 0);
        check_output("clear_state", state, 0);
        code_entry(16'h1234, 0); expect_unlock();
        press(4'hB, 0); press(4'd1, 0); press(4'hF, 0); press(4'd2, 0);
        press(4'hB, 0); press(4'd3, 0); press(4'hF, 0); press(4'd4, 0);
        expect_unlock();

        $display("[TB] keys in CHECK/UNLOCKED and async reset");
        code_entry(16'h1234, 0);
        press(4'd7, 0);
        check_output("key_in_check_unlock", unlock, 1);
        check_output("key_in_check_count", count, 4);
        repeat (2) @(negedge clk);
        press(4'd7, 0);
        check_output("key_in_unlocked", state, 3);
        #2 rst = 1'b0;
        #1;
        check_output("async_unlock", unlock, 0);
        check_output("async_state", state, 0);
        check_output("async_count", count, 0);
        check_output("async_entry", entry_active, 0);
        @(negedge clk);
        rst = 1'b1;
        code_entry(16'h1234, 0); expect_unlock();

`ifdef SMARTLOCK_PWCHANGE_EN
        $display("[TB] password change");
        code_entry(16'h1234, 0);
        repeat (2) @(negedge clk);
        press(4'hA, 0);
        check_output("newpw_state", state, 6);
        check_output("newpw_unlock", unlock, 0);
        check_output("newpw_entry", entry_active, 1);
        code_entry(16'h9876, 0);
        @(negedge clk);
        check_output("newpw_done", state, 0);
        code_entry(16'h1234, 0); expect_fail(1);
        @(negedge clk);
        code_entry(16'h9876, 0); expect_unlock();
        code_entry(16'h9876, 0);
        repeat (2) @(negedge clk);
        press(4'hA, 0);
        code_entry(16'h1234, 0);
        @(negedge clk);
        code_entry(16'h1234, 0);
        repeat (2) @(negedge clk);
        press(4'hA, 0);
        press(4'd5, 0);
        press(4'hC, 0);
        check_output("newpw_abort", state, 0);
        code_entry(16'h1234, 0); expect_unlock();
`endif

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
